// File: rtl/dcache_pkg.sv
// dcache_pkg: shared definitions for the direct-mapped write-back data cache.
//   LINES / WORDS / ADDR_W  cache geometry (LINES and WORDS powers of 2)
//   OFFSET_W / INDEX_W / TAG_W  address field widths derived from the geometry
//   state_t        controller states (IDLE, WB, REFILL)
//   addr_fields_t  word-address split {tag, index, offset}; byte bits [1:0] dropped
//   split_addr / beat_addr  helpers to decompose and rebuild byte addresses
package dcache_pkg;

  localparam int LINES    = 16;
  localparam int WORDS    = 4;
  localparam int ADDR_W   = 32;
  localparam int OFFSET_W = $clog2(WORDS);
  localparam int INDEX_W  = $clog2(LINES);
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W - 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WB     = 2'd1,
    REFILL = 2'd2
  } state_t;

  typedef struct packed {
    logic [TAG_W-1:0]    tag;
    logic [INDEX_W-1:0]  index;
    logic [OFFSET_W-1:0] offset;
  } addr_fields_t;

  function automatic addr_fields_t split_addr(input logic [ADDR_W-1:0] addr);
    split_addr = addr[ADDR_W-1:2];
  endfunction

  // Word-aligned byte address of one beat of a line.
  function automatic logic [ADDR_W-1:0] beat_addr(input logic [TAG_W-1:0]    tag,
                                                  input logic [INDEX_W-1:0]  index,
                                                  input logic [OFFSET_W-1:0] offset);
    beat_addr = {tag, index, offset, 2'b00};
  endfunction

endpackage

// File: rtl/dcache_array.sv
// dcache_array: tag/valid/dirty/data storage for the direct-mapped cache.
// Ports:
//   clk, rst                  clock; synchronous active-high reset clears valid and dirty
//   rd_index, rd_offset       combinational read address
//   rd_valid, rd_dirty, rd_tag, rd_word   combinational read data
//   wr_en, wr_index, wr_offset, wr_data   single data-word write port
//   meta_en, meta_valid, meta_dirty, meta_tag   metadata write for line wr_index
// Tags and data are not reset; a line is only trusted once its valid bit is set.
module dcache_array
  import dcache_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [INDEX_W-1:0]  rd_index,
  input  logic [OFFSET_W-1:0] rd_offset,
  output logic                rd_valid,
  output logic                rd_dirty,
  output logic [TAG_W-1:0]    rd_tag,
  output logic [31:0]         rd_word,
  input  logic                wr_en,
  input  logic [INDEX_W-1:0]  wr_index,
  input  logic [OFFSET_W-1:0] wr_offset,
  input  logic [31:0]         wr_data,
  input  logic                meta_en,
  input  logic                meta_valid,
  input  logic                meta_dirty,
  input  logic [TAG_W-1:0]    meta_tag
);

  logic [LINES-1:0] valid_q;
  logic [LINES-1:0] dirty_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES][WORDS];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (meta_en) begin
      valid_q[wr_index] <= meta_valid;
      dirty_q[wr_index] <= meta_dirty;
    end
  end

  always_ff @(posedge clk) begin
    if (meta_en) tag_q[wr_index] <= meta_tag;
    if (wr_en)   data_q[wr_index][wr_offset] <= wr_data;
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_dirty = dirty_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_word  = data_q[rd_index][rd_offset];

endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate data cache controller.
// Geometry (LINES, WORDS, ADDR_W) comes from dcache_pkg.
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   cpu_rd, cpu_wr       load / store request, held by the pipeline while hit=0
//                        (both together is a store)
//   cpu_addr, cpu_wdata  byte address (bits [1:0] ignored) and store data
//   cpu_rdata            load data, valid when cpu_rd && hit
//   hit                  1 = access complete or idle (pipeline advances), 0 = stall
//   mem_rd, mem_wr       memory beat requests
//   mem_addr, mem_wdata  word-aligned beat address and write-back data
//   mem_rdata, mem_ack   refill data and one-cycle beat completion
//   stat_hits, stat_misses  (only with DCACHE_STATS_EN) access counters
// Optional build macro: DCACHE_STATS_EN adds the hit/miss counters.
//
// Memory handshake: a beat is offered by raising mem_rd or mem_wr with
// mem_addr/mem_wdata; the request and its address/data stay stable until a
// cycle where mem_ack=1 completes it. The request then drops for exactly one
// cycle before the next beat. At most one beat is in flight, and mem_ack while
// no request is raised is ignored.
//
// The stalled pipeline holds cpu_addr across a miss, so the index and the
// requesting tag are taken straight from cpu_addr in WB and REFILL.
module dcache_ctrl
  import dcache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              hit,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       stat_hits,
  output logic [31:0]       stat_misses
`endif
);

  state_t              state, state_d;
  logic [OFFSET_W-1:0] beat, beat_d;
  logic                mem_rd_d, mem_wr_d;
  logic [ADDR_W-1:0]   mem_addr_d;
  logic [31:0]         mem_wdata_d;

  addr_fields_t        req;
  logic                is_req;
  logic                lookup_hit;
  logic                last_beat;
  logic                unused_byte_bits;

  logic [OFFSET_W-1:0] rd_offset;
  logic                rd_valid, rd_dirty;
  logic [TAG_W-1:0]    rd_tag;
  logic [31:0]         rd_word;
  logic                wr_en;
  logic [OFFSET_W-1:0] wr_offset;
  logic [31:0]         wr_data;
  logic                meta_en, meta_valid, meta_dirty;
  logic [TAG_W-1:0]    meta_tag;

  assign req              = split_addr(cpu_addr);
  assign is_req           = cpu_rd | cpu_wr;
  assign lookup_hit       = rd_valid && (rd_tag == req.tag);
  assign last_beat        = (beat == OFFSET_W'(WORDS - 1));
  assign unused_byte_bits = ^cpu_addr[1:0];

  dcache_array u_array (
    .clk        (clk),
    .rst        (rst),
    .rd_index   (req.index),
    .rd_offset  (rd_offset),
    .rd_valid   (rd_valid),
    .rd_dirty   (rd_dirty),
    .rd_tag     (rd_tag),
    .rd_word    (rd_word),
    .wr_en      (wr_en),
    .wr_index   (req.index),
    .wr_offset  (wr_offset),
    .wr_data    (wr_data),
    .meta_en    (meta_en),
    .meta_valid (meta_valid),
    .meta_dirty (meta_dirty),
    .meta_tag   (meta_tag)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      beat      <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= state_d;
      beat      <= beat_d;
      mem_rd    <= mem_rd_d;
      mem_wr    <= mem_wr_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
    end
  end

  always_comb begin
    state_d     = state;
    beat_d      = beat;
    mem_rd_d    = mem_rd;
    mem_wr_d    = mem_wr;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    hit         = 1'b0;
    cpu_rdata   = '0;
    rd_offset   = beat;
    wr_en       = 1'b0;
    wr_offset   = beat;
    wr_data     = mem_rdata;
    meta_en     = 1'b0;
    meta_valid  = 1'b0;
    meta_dirty  = 1'b0;
    meta_tag    = req.tag;

    unique case (state)
      IDLE: begin
        // On a miss the read port already points at word 0 so the first
        // write-back beat can be launched on the transition edge.
        rd_offset = (is_req && !lookup_hit) ? '0 : req.offset;
        if (!is_req) begin
          hit = 1'b1;
        end else if (lookup_hit) begin
          hit = 1'b1;
          if (cpu_wr) begin
            wr_en      = 1'b1;
            wr_offset  = req.offset;
            wr_data    = cpu_wdata;
            meta_en    = 1'b1;
            meta_valid = 1'b1;
            meta_dirty = 1'b1;
          end else begin
            cpu_rdata = rd_word;
          end
        end else begin
          beat_d = '0;
          if (rd_valid && rd_dirty) begin
            state_d     = WB;
            mem_wr_d    = 1'b1;
            mem_addr_d  = beat_addr(rd_tag, req.index, '0);
            mem_wdata_d = rd_word;
          end else begin
            state_d    = REFILL;
            mem_rd_d   = 1'b1;
            mem_addr_d = beat_addr(req.tag, req.index, '0);
          end
        end
      end

      WB: begin
        if (mem_wr) begin
          if (mem_ack) begin
            mem_wr_d = 1'b0;
            beat_d   = beat + 1'b1;
            if (last_beat) begin
              // Victim now matches memory; it stays valid until refill overwrites it.
              meta_en    = 1'b1;
              meta_valid = 1'b1;
              meta_dirty = 1'b0;
              meta_tag   = rd_tag;
              state_d    = REFILL;
            end
          end
        end else begin
          mem_wr_d    = 1'b1;
          mem_addr_d  = beat_addr(rd_tag, req.index, beat);
          mem_wdata_d = rd_word;
        end
      end

      REFILL: begin
        if (mem_rd) begin
          if (mem_ack) begin
            mem_rd_d   = 1'b0;
            beat_d     = beat + 1'b1;
            wr_en      = 1'b1;
            meta_en    = 1'b1;
            meta_dirty = 1'b0;
            // The line is marked invalid while partially filled.
            meta_valid = last_beat;
            if (last_beat) state_d = IDLE;
          end
        end else begin
          mem_rd_d   = 1'b1;
          mem_addr_d = beat_addr(req.tag, req.index, beat);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef DCACHE_STATS_EN
  logic count_hit, count_miss, refill_done, replay_q;

  assign count_hit   = (state == IDLE) && is_req && lookup_hit;
  assign count_miss  = (state == IDLE) && is_req && !lookup_hit;
  assign refill_done = (state == REFILL) && mem_rd && mem_ack && last_beat;

  // The cycle right after a refill is the replay of the held request; it is
  // already counted as a miss and must not also count as a hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      replay_q    <= 1'b0;
      stat_hits   <= '0;
      stat_misses <= '0;
    end else begin
      replay_q <= refill_done;
      if (count_hit && !replay_q) stat_hits <= stat_hits + 32'd1;
      if (count_miss) stat_misses <= stat_misses + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: self-checking bench for dcache_ctrl. A word-level memory
// responder answers beats; a line-level reference cache computes the expected
// hit/miss, load data and beat sequence for every access.
// Build with DCACHE_STATS_EN defined to also check the statistics counters.
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        rst, cpu_rd, cpu_wr, hit, mem_rd, mem_wr, mem_ack;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, mem_addr, mem_wdata, mem_rdata;
`ifdef DCACHE_STATS_EN
  logic [31:0] stat_hits, stat_misses;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  // Beat record: {is_write, address, data}
  logic [64:0] exp_q[$];
  logic [64:0] obs_q[$];

  logic [31:0] mem_words [logic [31:0]];
  logic [31:0] ref_mem   [logic [31:0]];
  bit          ref_valid [16];
  bit          ref_dirty [16];
  logic [23:0] ref_tag   [16];
  logic [31:0] ref_data  [16][4];
  int          exp_hits, exp_misses;

  int ack_delay = 2;
  bit rand_ack  = 1'b0;

  dcache_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_rd    (cpu_rd),
    .cpu_wr    (cpu_wr),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .hit       (hit),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
`ifdef DCACHE_STATS_EN
    ,
    .stat_hits   (stat_hits),
    .stat_misses (stat_misses)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- memory models ----------------
  function automatic logic [31:0] def_data(input logic [31:0] a);
    return ~a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    return mem_words.exists(a) ? mem_words[a] : def_data(a);
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : def_data(a);
  endfunction

  // Responder: acks each beat ack_delay cycles after the request appears,
  // checks the request is held stable and drops for the cycle after an ack.
  initial begin : mem_responder
    int          wait_cnt;
    bit          req_active;
    logic [31:0] held_addr, held_wdata;
    mem_ack = 1'b0;
    mem_rdata = '0;
    wait_cnt = 0;
    req_active = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        mem_ack = 1'b0;
        req_active = 1'b0;
        wait_cnt = 0;
      end else if (mem_ack) begin
        mem_ack = 1'b0;
        req_active = 1'b0;
        wait_cnt = 0;
        n_cmp++;
        if (mem_rd || mem_wr) begin
          n_fail++;
          $display("FAIL beat_gap: got rd=%b wr=%b after ack, required 0/0", mem_rd, mem_wr);
        end
      end else if (mem_rd || mem_wr) begin
        if (!req_active) begin
          req_active = 1'b1;
          held_addr = mem_addr;
          held_wdata = mem_wdata;
        end else begin
          n_cmp++;
          if (mem_addr !== held_addr || (mem_wr && mem_wdata !== held_wdata)) begin
            n_fail++;
            $display("FAIL beat_hold: got %h/%h required %h/%h", mem_addr, mem_wdata, held_addr, held_wdata);
          end
        end
        if (wait_cnt >= ack_delay) begin
          mem_ack = 1'b1;
          if (mem_wr) begin
            mem_words[mem_addr] = mem_wdata;
            obs_q.push_back({1'b1, mem_addr, mem_wdata});
          end else begin
            mem_rdata = mem_read(mem_addr);
            obs_q.push_back({1'b0, mem_addr, mem_rdata});
          end
          if (rand_ack) ack_delay = $urandom_range(0, 3);
        end else begin
          wait_cnt++;
        end
      end else begin
        req_active = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  // ---------------- reference cache ----------------
  task automatic reset_model();
    for (int i = 0; i < 16; i++) begin
      ref_valid[i] = 1'b0;
      ref_dirty[i] = 1'b0;
    end
    exp_hits = 0;
    exp_misses = 0;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic model_access(input bit rd, input bit wr, input logic [31:0] addr,
                              input logic [31:0] wdata, output bit exp_hit,
                              output logic [31:0] exp_rdata);
    logic [3:0]  idx;
    logic [1:0]  off, b2;
    logic [23:0] tg;
    logic [31:0] a, d;
    idx = addr[7:4];
    off = addr[3:2];
    tg  = addr[31:8];
    exp_rdata = '0;
    exp_hit = ref_valid[idx] && (ref_tag[idx] == tg);
    if (exp_hit) begin
      exp_hits++;
    end else begin
      exp_misses++;
      if (ref_valid[idx] && ref_dirty[idx]) begin
        for (int b = 0; b < 4; b++) begin
          b2 = b[1:0];
          a = {ref_tag[idx], idx, b2, 2'b00};
          ref_mem[a] = ref_data[idx][b];
          exp_q.push_back({1'b1, a, ref_data[idx][b]});
        end
      end
      for (int b = 0; b < 4; b++) begin
        b2 = b[1:0];
        a = {tg, idx, b2, 2'b00};
        d = ref_read(a);
        ref_data[idx][b] = d;
        exp_q.push_back({1'b0, a, d});
      end
      ref_valid[idx] = 1'b1;
      ref_dirty[idx] = 1'b0;
      ref_tag[idx] = tg;
    end
    if (wr) begin
      ref_data[idx][off] = wdata;
      ref_dirty[idx] = 1'b1;
    end else if (rd) begin
      exp_rdata = ref_data[idx][off];
    end
  endtask

  // ---------------- driver ----------------
  // Called just after a rising edge; holds the request until hit, returns the
  // number of stall cycles and the load data seen in the hit cycle.
  task automatic drive_access(input bit rd, input bit wr, input logic [31:0] addr,
                              input logic [31:0] wdata, output int stall,
                              output logic [31:0] rdata, output bit timeout);
    cpu_rd = rd;
    cpu_wr = wr;
    cpu_addr = addr;
    cpu_wdata = wdata;
    stall = 0;
    rdata = '0;
    timeout = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (hit) begin
        rdata = cpu_rdata;
        timeout = 1'b0;
        break;
      end
      stall++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    cpu_rd = 1'b0;
    cpu_wr = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    cpu_rd = 1'b0;
    cpu_wr = 1'b0;
    cpu_addr = '0;
    cpu_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (hit !== 1'b1) begin n_fail++; $display("FAIL reset_hit: got %b required 1", hit); end
    n_cmp++;
    if (cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h required 0", cpu_rdata); end
    n_cmp++;
    if (mem_rd !== 1'b0 || mem_wr !== 1'b0) begin
      n_fail++; $display("FAIL reset_mem_req: got rd=%b wr=%b required 0/0", mem_rd, mem_wr);
    end
    n_cmp++;
    if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_mem_bus: got %h/%h required 0/0", mem_addr, mem_wdata);
    end
`ifdef DCACHE_STATS_EN
    n_cmp++;
    if (stat_hits !== 32'h0 || stat_misses !== 32'h0) begin
      n_fail++; $display("FAIL reset_stats: got %0d/%0d required 0/0", stat_hits, stat_misses);
    end
`endif
    // All lines invalid: a request during reset must look like a miss.
    cpu_rd = 1'b1;
    cpu_addr = 32'h0000_0040;
    #1;
    n_cmp++;
    if (hit !== 1'b0) begin n_fail++; $display("FAIL reset_invalid: got hit=%b required 0", hit); end
    cpu_rd = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    reset_model();
  endtask

  task automatic test_cold_read();
    bit eh, to;
    logic [31:0] er, rd;
    int st;
    rand_ack = 1'b0;
    ack_delay = 2;
    for (int i = 0; i < 4; i++) begin
      mem_words[32'h40 + 4 * i] = 32'hA0 + i;
      ref_mem[32'h40 + 4 * i] = 32'hA0 + i;
    end
    model_access(1'b1, 1'b0, 32'h0000_0040, '0, eh, er);
    drive_access(1'b1, 1'b0, 32'h0000_0040, '0, st, rd, to);
    n_cmp++;
    if (to) begin n_fail++; $display("FAIL cold_timeout: no hit within budget"); end
    n_cmp++;
    if (st != 16) begin n_fail++; $display("FAIL cold_stall: got %0d cycles required 16", st); end
    n_cmp++;
    if (rd !== 32'hA0) begin n_fail++; $display("FAIL cold_rdata: got %h required a0", rd); end
    n_cmp++;
    if (obs_q.size() != 4) begin
      n_fail++; $display("FAIL cold_beats: got %0d beats required 4", obs_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (obs_q[i] !== {1'b0, 32'h40 + 32'(4 * i), 32'hA0 + 32'(i)}) begin
          n_fail++; $display("FAIL cold_beat%0d: got %h required %h", i, obs_q[i],
                             {1'b0, 32'h40 + 32'(4 * i), 32'hA0 + 32'(i)});
        end
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_read_hit();
    bit eh, to;
    logic [31:0] er, rd;
    int st;
    model_access(1'b1, 1'b0, 32'h0000_0048, '0, eh, er);
    drive_access(1'b1, 1'b0, 32'h0000_0048, '0, st, rd, to);
    n_cmp++;
    if (st != 0) begin n_fail++; $display("FAIL readhit_stall: got %0d required 0", st); end
    n_cmp++;
    if (rd !== 32'hA2) begin n_fail++; $display("FAIL readhit_rdata: got %h required a2", rd); end
    n_cmp++;
    if (obs_q.size() != 0) begin n_fail++; $display("FAIL readhit_mem: got %0d beats required 0", obs_q.size()); end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_write_evict();
    bit eh, to;
    logic [31:0] er, rd;
    int st;
    model_access(1'b0, 1'b1, 32'h0000_0044, 32'hDEAD_BEEF, eh, er);
    drive_access(1'b0, 1'b1, 32'h0000_0044, 32'hDEAD_BEEF, st, rd, to);
    n_cmp++;
    if (st != 0 || obs_q.size() != 0) begin
      n_fail++; $display("FAIL writehit: got stall=%0d beats=%0d required 0/0", st, obs_q.size());
    end
    model_access(1'b1, 1'b0, 32'h0000_0144, '0, eh, er);
    drive_access(1'b1, 1'b0, 32'h0000_0144, '0, st, rd, to);
    n_cmp++;
    if (st != 32) begin n_fail++; $display("FAIL evict_stall: got %0d required 32", st); end
    n_cmp++;
    if (rd !== er) begin n_fail++; $display("FAIL evict_rdata: got %h required %h", rd, er); end
    n_cmp++;
    if (obs_q.size() != 8) begin
      n_fail++; $display("FAIL evict_beats: got %0d required 8", obs_q.size());
    end else begin
      n_cmp++;
      if (obs_q[1] !== {1'b1, 32'h44, 32'hDEAD_BEEF}) begin
        n_fail++; $display("FAIL evict_wb44: got %h required %h", obs_q[1], {1'b1, 32'h44, 32'hDEAD_BEEF});
      end
      for (int i = 0; i < 8; i++) begin
        n_cmp++;
        if (obs_q[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL evict_beat%0d: got %h required %h", i, obs_q[i], exp_q[i]);
        end
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_store_miss();
    bit eh, to;
    logic [31:0] er, rd;
    int st;
    model_access(1'b0, 1'b1, 32'h0000_0280, 32'h1234, eh, er);
    drive_access(1'b0, 1'b1, 32'h0000_0280, 32'h1234, st, rd, to);
    n_cmp++;
    if (to || st != 16) begin n_fail++; $display("FAIL storemiss_stall: got %0d required 16", st); end
    n_cmp++;
    if (obs_q.size() != 4) begin
      n_fail++; $display("FAIL storemiss_beats: got %0d required 4", obs_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (obs_q[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL storemiss_beat%0d: got %h required %h", i, obs_q[i], exp_q[i]);
        end
      end
    end
    exp_q.delete();
    obs_q.delete();
    // Evicting the line must write the stored word back.
    model_access(1'b1, 1'b0, 32'h0000_0380, '0, eh, er);
    drive_access(1'b1, 1'b0, 32'h0000_0380, '0, st, rd, to);
    n_cmp++;
    if (obs_q.size() != 8) begin
      n_fail++; $display("FAIL storemiss_evict: got %0d beats required 8", obs_q.size());
    end else begin
      n_cmp++;
      if (obs_q[0] !== {1'b1, 32'h280, 32'h1234}) begin
        n_fail++; $display("FAIL storemiss_wb: got %h required %h", obs_q[0], {1'b1, 32'h280, 32'h1234});
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset_mid_refill();
    bit eh, to;
    logic [31:0] er, rd;
    int st;
    bit seen;
    ack_delay = 2;
    rand_ack = 1'b0;
    cpu_rd = 1'b1;
    cpu_wr = 1'b0;
    cpu_addr = 32'h0000_0350;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #2;
      if (obs_q.size() >= 2) begin seen = 1'b1; break; end
    end
    n_cmp++;
    if (!seen) begin n_fail++; $display("FAIL midrst_wait: got %0d beats required 2", obs_q.size()); end
    @(posedge clk); #1;
    rst = 1'b1;
    cpu_rd = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (mem_rd !== 1'b0 || mem_wr !== 1'b0) begin
      n_fail++; $display("FAIL midrst_req: got rd=%b wr=%b required 0/0", mem_rd, mem_wr);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    reset_model();
    model_access(1'b1, 1'b0, 32'h0000_0350, '0, eh, er);
    drive_access(1'b1, 1'b0, 32'h0000_0350, '0, st, rd, to);
    n_cmp++;
    if (to || st != 16) begin n_fail++; $display("FAIL midrst_refill_stall: got %0d required 16", st); end
    n_cmp++;
    if (rd !== er) begin n_fail++; $display("FAIL midrst_rdata: got %h required %h", rd, er); end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL midrst_beats: got %0d required %0d", obs_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        n_cmp++;
        if (obs_q[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL midrst_beat%0d: got %h required %h", i, obs_q[i], exp_q[i]);
        end
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_random();
    bit eh, to, rd_op, wr_op;
    logic [31:0] er, rd, addr, wd;
    int st, op;
    rand_ack = 1'b1;
    ack_delay = $urandom_range(0, 3);
    for (int k = 0; k < 80; k++) begin
      addr = {22'h0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
              2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      wd = $urandom;
      op = $urandom_range(0, 3);
      rd_op = (op <= 1) || (op == 3);
      wr_op = (op >= 2);
      model_access(rd_op, wr_op, addr, wd, eh, er);
      drive_access(rd_op, wr_op, addr, wd, st, rd, to);
      n_cmp++;
      if (to) begin n_fail++; $display("FAIL rand_timeout[%0d]: addr %h", k, addr); end
      n_cmp++;
      if ((st == 0) != eh) begin
        n_fail++; $display("FAIL rand_hit[%0d]: got stall=%0d required hit=%b addr %h", k, st, eh, addr);
      end
      if (rd_op && !wr_op) begin
        n_cmp++;
        if (rd !== er) begin n_fail++; $display("FAIL rand_rdata[%0d]: got %h required %h", k, rd, er); end
      end
      n_cmp++;
      if (obs_q.size() != exp_q.size()) begin
        n_fail++; $display("FAIL rand_beats[%0d]: got %0d required %0d", k, obs_q.size(), exp_q.size());
      end else begin
        foreach (exp_q[i]) begin
          n_cmp++;
          if (obs_q[i] !== exp_q[i]) begin
            n_fail++; $display("FAIL rand_beat[%0d.%0d]: got %h required %h", k, i, obs_q[i], exp_q[i]);
          end
        end
      end
      exp_q.delete();
      obs_q.delete();
    end
    rand_ack = 1'b0;
  endtask

`ifdef DCACHE_STATS_EN
  task automatic test_stats();
    @(negedge clk);
    n_cmp++;
    if (stat_hits !== 32'(exp_hits)) begin
      n_fail++; $display("FAIL stat_hits: got %0d required %0d", stat_hits, exp_hits);
    end
    n_cmp++;
    if (stat_misses !== 32'(exp_misses)) begin
      n_fail++; $display("FAIL stat_misses: got %0d required %0d", stat_misses, exp_misses);
    end
    @(posedge clk); #1;
  endtask
`endif

  initial begin : main
    test_reset();
    test_cold_read();
    test_read_hit();
    test_write_evict();
    test_store_miss();
`ifdef DCACHE_STATS_EN
    test_stats();
`endif
    test_reset_mid_refill();
    test_random();
`ifdef DCACHE_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data cache controller.
- Sits between the EX/MEM stage and main memory. It answers pipeline load/store requests and drives `hit`, the advance/stall qualifier consumed by every pipeline register.
- `hit`=1 lets pipeline registers capture. `hit`=0 freezes them until a miss is serviced over a word-serial memory handshake.

Parameters:
- LINES, 16, number of cache lines (power of 2).
- WORDS, 4, 32-bit words per line (power of 2).
- ADDR_W, 32, byte-address width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- cpu_rd  in  1  load request, held by the stalled pipeline until hit=1.
- cpu_wr  in  1  store request, held likewise.
- cpu_addr  in  ADDR_W  byte address; bits [1:0] ignored.
- cpu_wdata  in  32  store data.
- cpu_rdata  out  32  load data, valid when cpu_rd && hit.
- hit  out  1  1 = access complete or no access (pipeline may advance); 0 = stall.
- mem_rd  out  1  memory read beat request.
- mem_wr  out  1  memory write beat request.
- mem_addr  out  ADDR_W  word-aligned beat address.
- mem_wdata  out  32  write-back data.
- mem_rdata  in  32  read data, valid with mem_ack.
- mem_ack  in  1  one-cycle beat completion.

Behaviour:
- Address split (defaults):
  - offset = addr[3:2]
  - index = addr[7:4]
  - tag = addr[31:8]
  - Widths derive from log2 of WORDS and LINES.
- Per line state: valid, dirty, tag, data[WORDS].
- Reset: all valid and dirty bits cleared; state IDLE; mem_rd=mem_wr=0; mem_addr=0; mem_wdata=0; beat counter 0; hit=1; cpu_rdata=0.
- Reset mid-operation: any in-flight beat is abandoned. mem_rd/mem_wr are low the cycle after rst. A partially refilled line stays invalid.
- Request arbitration: cpu_rd && cpu_wr together is treated as a store.
- Lookup:
  - A lookup hits when valid[index] && tag match.
  - hit is combinational in IDLE: 1 if no request or lookup hits, else 0.
  - hit=0 in every other state.
- Read hit: cpu_rdata = data[index][offset] in the same cycle (0-cycle latency).
- Write hit: word written and dirty set at the clock edge where hit=1.
- FSM states: IDLE, WB, REFILL.
  - IDLE, miss with victim valid && dirty: go to WB, beat=0.
  - IDLE, miss with clean or invalid victim: go to REFILL, beat=0.
  - WB:
    - mem_wr=1, mem_addr={victim_tag, index, beat, 2'b00}, mem_wdata=data[index][beat].
    - Address and data are held stable until mem_ack.
    - On mem_ack: beat++. On the last beat, clear dirty and go to REFILL with beat=0.
  - REFILL:
    - mem_rd=1, mem_addr={cpu_tag, index, beat, 2'b00}, held until mem_ack.
    - On mem_ack: data[index][beat] = mem_rdata.
    - On the last ack: set valid, tag=cpu_tag, dirty=0, go to IDLE.
- Replay after refill: the held request re-looks-up in IDLE and hits. A store is applied then, marking the line dirty.
- Beat timing: at most one beat in flight. mem_rd/mem_wr deassert for exactly one cycle after each ack before the next beat.
- Miss latency:
  - Clean miss: WORDS handshakes + 1 replay cycle.
  - Dirty miss: 2*WORDS handshakes + 1.
- mem_ack outside WB/REFILL is ignored.
- Counters wrap modulo WORDS.

Optional Feature:
- Macro: DCACHE_STATS_EN.
- When defined:
  - Adds outputs stat_hits[31:0] and stat_misses[31:0].
  - stat_hits increments once per request completed with hit=1 in IDLE, excluding replays after a refill.
  - stat_misses increments once per IDLE→WB or IDLE→REFILL transition.
  - Both are cleared by rst and wrap at 2^32.
- When undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package `dcache_pkg` holds:
  - LINES, WORDS and the derived OFFSET_W, INDEX_W, TAG_W.
  - The state enum (IDLE, WB, REFILL).
  - An address-field typedef struct {tag, index, offset}.
- One natural sub-module: `dcache_array`. It holds the tag/valid/dirty/data storage, with a combinational read port plus a single write port (CPU word write or refill word write), so the FSM stays separate from the storage.

Test Plan:
- Cold read: after rst, cpu_rd addr 0x0000_0040, mem_ack 2 cycles after each mem_rd, mem_rdata = 0xA0+beat. Expect hit=0, beats at mem_addr 0x40, 0x44, 0x48, 0x4C, then hit=1 with cpu_rdata=0xA0.
- Read hit: cpu_rd 0x0000_0048 after the line is filled. Expect hit=1 in the same cycle, cpu_rdata=0xA2, and no memory activity.
- Write hit then dirty eviction:
  - cpu_wr 0x44 with data 0xDEAD_BEEF: expect hit=1 and no memory traffic.
  - Then cpu_rd 0x0000_0144 (same index, new tag): expect 4 WB beats at 0x40–0x4C, with mem_wdata at 0x44 = 0xDEAD_BEEF, followed by 4 REFILL beats at 0x140–0x14C.
- Store miss: cpu_wr 0x0000_0280 data 0x1234 on a clean line. Expect REFILL of 0x280–0x28C, then hit=1, and the line is dirty (proved by a later eviction writing 0x1234 back).
- Reset mid-refill: assert rst after the 2nd REFILL ack. Expect mem_rd=0 the next cycle, and a subsequent read of the same address misses with a full 4-beat refill.
- Stats (DCACHE_STATS_EN): run the above sequence and expect the final stat_hits/stat_misses to match a scoreboard count exactly.
